// File: rtl/rx_ram.sv
// rx_ram: byte-capture RAM behind the UART receiver, with a registered read port for replay.
// Optional feature macro RX_RAM_WRAP_EN: keep capturing past full by overwriting the oldest cell.
module rx_ram #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TERM       = DATA_WIDTH'(8'h0A)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   len,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            state_dbg
);

    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEN_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LEN_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Handshake: wr_en is a one-cycle strobe with no ready; a byte offered
    // while the frame is DONE (or alongside clr) is simply lost.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        mem_we   = 1'b0;
        if (clr) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            len_d    = '0;
            ovf_d    = 1'b0;
        end else if (wr_en) begin
            if (state_q == DONE) begin
                ovf_d = 1'b1;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                state_d  = FILL;
                if (len_q != LEN_FULL) begin
                    len_d = len_q + (ADDR_WIDTH+1)'(1);
                end
`ifdef RX_RAM_WRAP_EN
                // Once full, every accepted byte overwrites the oldest cell.
                if (len_q == LEN_FULL) begin
                    ovf_d = 1'b1;
                end
`else
                if (len_q == LEN_LAST) begin
                    state_d = DONE;
                end
`endif
                if (wr_data == TERM) begin
                    state_d = DONE;
                end
            end
        end
        done_d    = (state_d == DONE);
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            len_q     <= len_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage has no reset so it maps onto plain RAM; reads see the pre-write value.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign len       = len_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule
